cnn_image_loader: RTL and testbench
===================================

Name: cnn_image_loader

Overview:
- Streaming writer for the CNN input image buffer: accepts a byte-wide pixel stream (valid/ready), writes NUM_PIXELS pixels into the 28x28 image memory, then drives the classifier start/done handshake.
- Latches the predicted digit and pulses result_valid once per frame.
- Sits in front of the CNN top level and replaces file-based image loading for on-FPGA and streamed-testbench operation.

Parameters:
- NUM_PIXELS, 784, pixels per frame (28x28).
- ADDR_W, 10, image memory address width; 2**ADDR_W >= NUM_PIXELS.
- DATA_W, 8, pixel width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_valid  input  1  pixel byte valid.
- s_data  input  DATA_W  pixel value.
- s_sof  input  1  start-of-frame marker, qualified by s_valid.
- s_ready  output  1  loader can accept a pixel.
- mem_we  output  1  image memory write enable.
- mem_addr  output  ADDR_W  image memory write address.
- mem_wdata  output  DATA_W  image memory write data.
- cnn_start  output  1  classifier start, level, held until cnn_done seen.
- cnn_done  input  1  classifier completion flag, level.
- cnn_result  input  4  classifier predicted digit.
- result  output  4  latched digit of last completed frame.
- result_valid  output  1  one-cycle pulse when result updates.
- frame_count  output  8  completed frames, wraps 255->0.
- sof_err  output  1  sticky: s_sof seen mid-frame.

Behaviour:
- Reset (rst low, async):
  - State LOAD, pixel counter 0, s_ready 1.
  - mem_we 0, mem_addr 0, mem_wdata 0, cnn_start 0.
  - result 0, result_valid 0, frame_count 0, sof_err 0.
  - Reset mid-frame or mid-compute discards the partial frame; cnn_start drops asynchronously.
- States:
  - LOAD: s_ready=1. On accept (s_valid && s_ready), the next cycle registers mem_we=1, mem_addr=counter, mem_wdata=s_data. One-cycle write latency; one pixel per cycle sustained.
  - Accepted pixel with s_sof=1: written to address 0 and counter set to 1. If counter was nonzero at that point, set sof_err (frame resync). s_sof with counter already 0 is legal.
  - When the accepted pixel is index NUM_PIXELS-1: s_ready drops the following cycle, then go to START.
  - START: cnn_start=1 one cycle after the last mem_we, so the memory write completes first. Go to WAIT.
  - WAIT: s_ready=0, cnn_start held 1. On cnn_done=1: latch result<=cnn_result, pulse result_valid for one cycle, frame_count+1, cnn_start<=0, go to RELEASE.
  - RELEASE: s_ready=0. Wait for cnn_done=0 (classifier returns to idle once start is low), then go to LOAD with counter 0.
- s_valid while s_ready=0: ignored; the source must hold the data.
- cnn_done already high on entry to WAIT: accepted immediately; there is no stale-done filtering.
- mem_we is never asserted outside LOAD-driven writes.
- sof_err is cleared only by reset.

Optional Feature:
- Macro: IMG_CHECKSUM_EN.
- When defined:
  - Extra output pixel_sum [17:0]: unsigned sum of all pixels of the last completed frame.
  - Updated together with result_valid; the accumulator clears on frame start (counter 0 or s_sof).
  - 18 bits covers 784*255 with no overflow.
- When undefined: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package cnn_pkg:
  - Constants IMG_W=28, IMG_PIXELS=784, PIX_W=8, IMG_ADDR_W=10, DIGIT_W=4.
  - State enum {LOAD, START, WAIT, RELEASE}.
- One sub-module, cnn_start_handshake: implements START/WAIT/RELEASE, latches result, generates the result_valid pulse and frame_count.
- The loader keeps the stream/write-address logic.

Test Plan:
- Back-to-back 784 bytes, value = index mod 256, s_valid always 1:
  - mem_we high for 784 consecutive cycles, addresses 0..783 in order.
  - cnn_start rises exactly one cycle after the last mem_we; s_ready low from then on.
- Model cnn_done=1 10 cycles after cnn_start with cnn_result=7:
  - result=7, result_valid high for exactly 1 cycle, cnn_start low the next cycle, frame_count=1.
  - s_ready stays 0 until cnn_done falls, then returns to 1.
- 300 bytes, then s_sof=1 with data 0xAA:
  - sof_err=1; next mem_we has addr 0, data 0xAA.
  - A further 783 bytes then trigger cnn_start.
- s_valid toggled randomly and bytes offered while in WAIT:
  - No mem_we in WAIT; exactly 784 writes per frame; data order preserved.
- rst pulsed low at pixel 500 and again during WAIT:
  - All outputs return to reset values immediately (async), cnn_start=0.
  - The next frame loads from address 0.
- IMG_CHECKSUM_EN defined, all pixels 0xFF:
  - pixel_sum=199920 at result_valid.
  - Second frame of all 0x01 gives pixel_sum=784.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and controller state encoding for the CNN image loader slice.
package cnn_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_PIXELS = IMG_W * IMG_W;
    localparam int PIX_W      = 8;
    localparam int IMG_ADDR_W = 10;
    localparam int DIGIT_W    = 4;
    localparam int SUM_W      = 18;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        RELEASE
    } cnn_state_t;

endpackage

// File: rtl/cnn_start_handshake.sv
// Frame controller: sequences LOAD/START/WAIT/RELEASE around the classifier
// start/done handshake and latches the predicted digit once per frame.
module cnn_start_handshake
    import cnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_loaded,
    input  logic               cnn_done,
    input  logic [DIGIT_W-1:0] cnn_result,
    output cnn_state_t         state,
    output logic               cnn_start,
    output logic [DIGIT_W-1:0] result,
    output logic               result_valid,
    output logic [7:0]         frame_count
);

    cnn_state_t next_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // RELEASE waits for done to fall so a level-held done cannot retrigger the next frame.
    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (frame_loaded) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (cnn_done) next_state = RELEASE;
            RELEASE: if (!cnn_done) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnn_start    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            frame_count  <= '0;
        end else begin
            result_valid <= 1'b0;
            if (state == START) begin
                cnn_start <= 1'b1;
            end
            if (state == WAIT && cnn_done) begin
                cnn_start    <= 1'b0;
                result       <= cnn_result;
                result_valid <= 1'b1;
                frame_count  <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/cnn_image_loader.sv
// Streams a byte-wide pixel frame into the CNN image memory, then hands off to the classifier.
// Optional IMG_CHECKSUM_EN adds a pixel_sum output holding the sum of the last completed frame.
module cnn_image_loader
    import cnn_pkg::*;
#(
    parameter int NUM_PIXELS = IMG_PIXELS,
    parameter int ADDR_W     = IMG_ADDR_W,
    parameter int DATA_W     = PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_sof,
    output logic               s_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               cnn_start,
    input  logic               cnn_done,
    input  logic [DIGIT_W-1:0] cnn_result,
    output logic [DIGIT_W-1:0] result,
    output logic               result_valid,
    output logic [7:0]         frame_count,
    output logic               sof_err
`ifdef IMG_CHECKSUM_EN
    ,
    output logic [SUM_W-1:0]   pixel_sum
`endif
);

    cnn_state_t        state;
    logic [ADDR_W-1:0] pix_count;
    logic              accept;
    logic              last_pixel;

    assign s_ready    = (state == LOAD);
    assign accept     = s_valid && s_ready;
    assign last_pixel = accept && !s_sof && (pix_count == ADDR_W'(NUM_PIXELS - 1));

    // A start-of-frame pixel always lands at address 0; arriving mid-frame flags a resync.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_count <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sof_err   <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_wdata <= s_data;
                if (s_sof) begin
                    mem_addr  <= '0;
                    pix_count <= ADDR_W'(1);
                    if (pix_count != '0) begin
                        sof_err <= 1'b1;
                    end
                end else begin
                    mem_addr  <= pix_count;
                    pix_count <= last_pixel ? '0 : pix_count + ADDR_W'(1);
                end
            end
        end
    end

`ifdef IMG_CHECKSUM_EN
    logic [SUM_W-1:0] pix_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_acc   <= '0;
            pixel_sum <= '0;
        end else begin
            if (accept) begin
                pix_acc <= (s_sof || pix_count == '0) ? SUM_W'(s_data)
                                                      : pix_acc + SUM_W'(s_data);
            end
            if (state == WAIT && cnn_done) begin
                pixel_sum <= pix_acc;
            end
        end
    end
`endif

    cnn_start_handshake u_handshake (
        .clk          (clk),
        .rst          (rst),
        .frame_loaded (last_pixel),
        .cnn_done     (cnn_done),
        .cnn_result   (cnn_result),
        .state        (state),
        .cnn_start    (cnn_start),
        .result       (result),
        .result_valid (result_valid),
        .frame_count  (frame_count)
    );

endmodule

// File: tb/tb_cnn_image_loader.sv
// Directed bench for cnn_image_loader: frame loads, resync, throttled stream, async resets
// and, when IMG_CHECKSUM_EN is defined, the frame pixel sum.
module tb_cnn_image_loader;
    import cnn_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic [7:0]   s_data = 8'h00;
    logic         s_sof = 1'b0;
    logic         s_ready;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [7:0]   mem_wdata;
    logic         cnn_start;
    logic         cnn_done = 1'b0;
    logic [3:0]   cnn_result = 4'd0;
    logic [3:0]   result;
    logic         result_valid;
    logic [7:0]   frame_count;
    logic         sof_err;
`ifdef IMG_CHECKSUM_EN
    logic [17:0]  pixel_sum;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;

    cnn_image_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_sof        (s_sof),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cnn_start    (cnn_start),
        .cnn_done     (cnn_done),
        .cnn_result   (cnn_result),
        .result       (result),
        .result_valid (result_valid),
        .frame_count  (frame_count),
        .sof_err      (sof_err)
`ifdef IMG_CHECKSUM_EN
        ,
        .pixel_sum    (pixel_sum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic logic [7:0] pixVal(input int mode, input int idx);
        case (mode)
            1:       return 8'hFF;
            2:       return 8'h01;
            default: return 8'(idx % 256);
        endcase
    endfunction

    task automatic applyStimulus(input logic valid, input logic sof, input logic [7:0] data);
        s_valid = valid;
        s_sof   = sof;
        s_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_s_ready",      32'(s_ready), 1);
        checkOutput("rst_mem_we",       32'(mem_we), 0);
        checkOutput("rst_mem_addr",     32'(mem_addr), 0);
        checkOutput("rst_mem_wdata",    32'(mem_wdata), 0);
        checkOutput("rst_cnn_start",    32'(cnn_start), 0);
        checkOutput("rst_result",       32'(result), 0);
        checkOutput("rst_result_valid", 32'(result_valid), 0);
        checkOutput("rst_frame_count",  32'(frame_count), 0);
        checkOutput("rst_sof_err",      32'(sof_err), 0);
`ifdef IMG_CHECKSUM_EN
        checkOutput("rst_pixel_sum",    32'(pixel_sum), 0);
`endif
    endtask

    task automatic loadPixels(input int first_idx, input int count, input int mode);
        int idx;
        for (int k = 0; k < count; k++) begin
            idx = first_idx + k;
            checkOutput("load_s_ready", 32'(s_ready), 1);
            applyStimulus(1'b1, 1'b0, pixVal(mode, idx));
            @(negedge clk);
            checkOutput("load_write", 32'({mem_we, mem_addr, mem_wdata}),
                        32'({1'b1, 10'(idx), pixVal(mode, idx)}));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Entered at the negedge right after the last pixel write is visible.
    task automatic completeFrame(input int early_done, input int hold_cycles,
                                 input logic [3:0] digit, input int exp_sum);
        checkOutput("last_s_ready",  32'(s_ready), 0);
        checkOutput("last_cnn_start", 32'(cnn_start), 0);
        if (early_done != 0) begin
            cnn_done   = 1'b1;
            cnn_result = digit;
        end
        @(negedge clk);
        checkOutput("start_mem_we", 32'(mem_we), 0);
        checkOutput("start_rise",   32'(cnn_start), 1);
        for (int c = 0; c < hold_cycles; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(0, 255)));
            @(negedge clk);
            checkOutput("wait_hold", 32'({mem_we, s_ready, cnn_start, result_valid}), 2);
        end
        cnn_done   = 1'b1;
        cnn_result = digit;
        @(negedge clk);
        exp_frames++;
        checkOutput("done_result",       32'(result), 32'(digit));
        checkOutput("done_result_valid", 32'(result_valid), 1);
        checkOutput("done_cnn_start",    32'(cnn_start), 0);
        checkOutput("done_frame_count",  32'(frame_count), exp_frames % 256);
        checkOutput("done_s_ready",      32'(s_ready), 0);
`ifdef IMG_CHECKSUM_EN
        checkOutput("done_pixel_sum",    32'(pixel_sum), exp_sum);
`endif
        $display("[TB] frame %0d classified, reference pixel sum %0d", exp_frames, exp_sum);
        @(negedge clk);
        checkOutput("release_pulse_end", 32'(result_valid), 0);
        checkOutput("release_s_ready",   32'(s_ready), 0);
        checkOutput("release_mem_we",    32'(mem_we), 0);
        cnn_done = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("reload_s_ready", 32'(s_ready), 1);
        checkOutput("reload_result",  32'(result), 32'(digit));
    endtask

    initial begin
        int         dut_writes;
        int         accepted;
        int         cycles;
        int         rsum;
        logic       v;
        logic       pend;
        logic [7:0] d;

        $display("[TB] start");
        repeat (2) @(negedge clk);
        checkReset();
        rst = 1'b1;
        @(negedge clk);
        checkReset();

        // Frame 1: back-to-back ramp, source keeps s_valid high past the frame end.
        loadPixels(0, 784, 0);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        completeFrame(0, 9, 4'd7, 98040);

        // Frame 2: resync after 300 bytes, done already high when WAIT is entered.
        loadPixels(0, 300, 0);
        checkOutput("sof_err_before", 32'(sof_err), 0);
        applyStimulus(1'b1, 1'b1, 8'hAA);
        @(negedge clk);
        checkOutput("sof_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 10'd0, 8'hAA}));
        checkOutput("sof_err_set", 32'(sof_err), 1);
        loadPixels(1, 783, 0);
        completeFrame(1, 0, 4'd3, 98210);
        checkOutput("sof_err_sticky", 32'(sof_err), 1);

        // Frame 3: randomly throttled stream, data order checked against a running model.
        dut_writes = 0;
        accepted   = 0;
        cycles     = 0;
        rsum       = 0;
        while (dut_writes < 784 && cycles < 5000) begin
            v    = 1'($urandom_range(0, 1));
            pend = v && s_ready;
            d    = 8'((accepted * 7 + 3) % 256);
            applyStimulus(v, 1'b0, d);
            @(negedge clk);
            cycles++;
            if (mem_we) dut_writes++;
            checkOutput("rand_we", 32'(mem_we), 32'(pend));
            if (pend) begin
                checkOutput("rand_write", 32'({mem_addr, mem_wdata}), 32'({10'(accepted), d}));
                rsum += int'(d);
                accepted++;
            end
        end
        checkOutput("rand_write_count", dut_writes, 784);
        completeFrame(0, 12, 4'd9, rsum);

        // Async reset at pixel 500, then again while waiting on the classifier.
        loadPixels(0, 500, 0);
        #2 rst = 1'b0;
        #1 checkReset();
        @(negedge clk);
        rst = 1'b1;
        exp_frames = 0;
        loadPixels(0, 784, 1);
        checkOutput("pre_wait_s_ready", 32'(s_ready), 0);
        @(negedge clk);
        checkOutput("pre_reset_cnn_start", 32'(cnn_start), 1);
        #2 rst = 1'b0;
        #1 checkReset();
        @(negedge clk);
        rst = 1'b1;

        // Post-reset frames: all 0xFF, then all 0x01 opened with a legal s_sof.
        loadPixels(0, 784, 1);
        completeFrame(0, 9, 4'd2, 199920);
        applyStimulus(1'b1, 1'b1, 8'h01);
        @(negedge clk);
        checkOutput("legal_sof_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 10'd0, 8'h01}));
        checkOutput("legal_sof_no_err", 32'(sof_err), 0);
        loadPixels(1, 783, 2);
        completeFrame(0, 9, 4'd4, 784);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
